main_mem_line: RTL and testbench

MAIN_MEM_LINE -- requirements
Module: main_mem_line

---
 rtl/main_mem_pkg.sv | 14 +
 rtl/main_mem_line_array.sv | 27 ++
 rtl/main_mem_line.sv | 123 ++++++++++++
 tb/tb_main_mem_line.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/main_mem_pkg.sv
// Shared types and sizes for the line-oriented main memory model.
package main_mem_pkg;
  localparam int LINE_WORDS = 4;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = 128;
  localparam int ADDR_W     = 10;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    DONE
  } state_t;
endpackage

// File: rtl/main_mem_line_array.sv
// Word-write / line-read storage array; contents are never reset.
module mem_array
  import main_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [WORD_W-1:0]   wdata,
  input  logic                re,
  input  logic [ADDR_W-3:0]   rline,
  output logic [LINE_W-1:0]   rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        rdata[i*WORD_W +: WORD_W] <= mem[{rline, 2'(i)}];
      end
    end
  end

endmodule

// File: rtl/main_mem_line.sv
// Fixed-latency main memory: single-word writes, 4-word line reads.
// Optional rd_count/wr_count statistics outputs when MAIN_MEM_STATS_EN is defined.
//
// state   | meaning
// IDLE    | waiting; a write wins over a simultaneous read
// RD_WAIT | line read in flight, counter running down
// WR_WAIT | word write in flight, counter running down
// DONE    | ready pulse; write commits / read line presented
module main_mem_line
  import main_mem_pkg::*;
#(
  parameter int LATENCY     = 4,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MsRead,
  input  logic                MemWrite,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [WORD_W-1:0]   data_in,
  output logic [LINE_W-1:0]   MsData_out,
  output logic                ready,
  output logic                busy
`ifdef MAIN_MEM_STATS_EN
  ,
  output logic [15:0]         rd_count,
  output logic [15:0]         wr_count
`endif
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                op_wr;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   data_q;
  logic [LINE_W-1:0]   line_q;
  logic [LINE_W-1:0]   arr_line;
  logic                accept;
  logic                arr_we;

  assign accept = (state == IDLE) && (MemWrite || MsRead);
  // reset on the commit edge must suppress the write
  assign arr_we = (state == DONE) && op_wr && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      line_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == DONE && !op_wr) line_q <= arr_line;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_wr  <= MemWrite;
      addr_q <= addr;
      data_q <= data_in;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (MemWrite) begin
          state_nxt = WR_WAIT;
          cnt_nxt   = CNT_LOAD;
        end else if (MsRead) begin
          state_nxt = RD_WAIT;
          cnt_nxt   = CNT_LOAD;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (cnt == 4'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // the array output is valid during DONE of a read; line_q holds it afterwards
  assign MsData_out = (state == DONE && !op_wr) ? arr_line : line_q;

  mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (addr_q),
    .wdata (data_q),
    .re    (state == RD_WAIT),
    .rline (addr_q[ADDR_W-1:2]),
    .rdata (arr_line)
  );

`ifdef MAIN_MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == DONE) begin
      if (op_wr) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_main_mem_line.sv
// Bench for main_mem_line; with MAIN_MEM_STATS_EN defined it runs at LATENCY=2 and checks the counters.
`timescale 1ns/1ps
module tb_main_mem_line;
`ifdef MAIN_MEM_STATS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 4;
`endif
  localparam int RST_DLY = (LAT > 2) ? 2 : 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         MsRead = 1'b0;
  logic         MemWrite = 1'b0;
  logic [9:0]   addr = '0;
  logic [31:0]  data_in = '0;
  logic [127:0] MsData_out;
  logic         ready, busy;
`ifdef MAIN_MEM_STATS_EN
  logic [15:0]  rd_count, wr_count;
`endif

  int checks = 0;
  int errors = 0;

  main_mem_line #(.LATENCY(LAT), .DEPTH_WORDS(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .MsRead     (MsRead),
    .MemWrite   (MemWrite),
    .addr       (addr),
    .data_in    (data_in),
    .MsData_out (MsData_out),
    .ready      (ready),
    .busy       (busy)
`ifdef MAIN_MEM_STATS_EN
    ,
    .rd_count   (rd_count),
    .wr_count   (wr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: edge counting plus a word array.
  logic [31:0]  m_mem [1024];
  logic [127:0] m_line = '0;
  logic [9:0]   m_a;
  logic [31:0]  m_d;
  bit           m_valid = 0, m_act = 0, m_wr = 0;
  int           ecur = 0, m_done = 0, m_next = 0, m_rd = 0, m_wrn = 0;

  always @(posedge clk) begin
    ecur++;
    if (reset) begin
      m_valid = 1; m_act = 0; m_line = '0; m_rd = 0; m_wrn = 0; m_next = ecur + 1;
    end else if (m_valid) begin
      if (m_act && !m_wr && ecur == m_done)
        for (int w = 0; w < 4; w++) m_line[w*32 +: 32] = m_mem[{m_a[9:2], 2'(w)}];
      if (m_act && ecur == m_done + 1) begin
        if (m_wr) begin
          m_mem[m_a] = m_d;
          if (m_wrn < 65535) m_wrn++;
        end else if (m_rd < 65535) m_rd++;
        m_act = 0;
        m_next = ecur + 1;
      end
      if (!m_act && ecur >= m_next && (MemWrite || MsRead)) begin
        m_act = 1; m_wr = MemWrite; m_a = addr; m_d = data_in; m_done = ecur + LAT - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("ready", ready, m_act && ecur == m_done);
      chk("busy", busy, m_act);
      chk("MsData_out", MsData_out, m_line);
`ifdef MAIN_MEM_STATS_EN
      chk("rd_count", rd_count, 16'(m_rd));
      chk("wr_count", wr_count, 16'(m_wrn));
`endif
    end
  end

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!ready && n < 40);
    if (!ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: no ready within %0d cycles at %0t", n, $time);
    end
  endtask

  task automatic req(input bit rd, input bit wr, input logic [9:0] a, input logic [31:0] d, output int n);
    @(negedge clk);
    MsRead = rd; MemWrite = wr; addr = a; data_in = d;
    wait_ready(n);
    MsRead = 0; MemWrite = 0;
  endtask

  initial begin
    int n;
    int rdy_seen;
    bit stable;
    logic [127:0] cap;

    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_ready", ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", MsData_out, 128'h0);

    for (int i = 0; i < 20; i++) req(0, 1, 10'(i), 32'h1000_0000 + 32'(i), n);
    for (int i = 0; i < 4; i++) req(0, 1, 10'(32 + i), 32'hA5A5_0020 + 32'(i), n);

    req(0, 1, 10'h005, 32'hDEADBEEF, n);
    chk("wr_latency", n, LAT);
    req(1, 0, 10'h004, 32'h0, n);
    chk("rd_latency", n, LAT);
    chk("rd_word1", MsData_out[63:32], 32'hDEADBEEF);
    chk("rd_word0", MsData_out[31:0], 32'h1000_0004);
    chk("rd_word3", MsData_out[127:96], 32'h1000_0007);

    @(negedge clk);
    MsRead = 1; MemWrite = 1; addr = 10'h010; data_in = 32'hCAFE_0010;
    wait_ready(n);
    chk("both_wr_latency", n, LAT);
    MemWrite = 0;
    wait_ready(n);
    chk("both_rd_latency", n, LAT + 1);
    chk("both_rd_new", MsData_out[31:0], 32'hCAFE_0010);
    chk("both_rd_word1", MsData_out[63:32], 32'h1000_0011);
    MsRead = 0;

    @(negedge clk);
    @(negedge clk);
    MemWrite = 1; addr = 10'h020; data_in = 32'h1234_5678;
    rdy_seen = 0;
    repeat (RST_DLY) begin
      @(negedge clk);
      rdy_seen += int'(ready);
    end
    reset = 1; MemWrite = 0;
    @(negedge clk);
    rdy_seen += int'(ready);
    reset = 0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_data", MsData_out, 128'h0);
    repeat (2 * LAT) begin
      @(negedge clk);
      rdy_seen += int'(ready);
    end
    chk("abort_no_ready", rdy_seen, 0);
    req(1, 0, 10'h020, 32'h0, n);
    chk("abort_old_word", MsData_out[31:0], 32'hA5A5_0020);

    @(negedge clk);
    MsRead = 1; addr = 10'h000;
    wait_ready(n);
    cap = MsData_out;
    chk("b2b_line0", cap[31:0], 32'h1000_0000);
    addr = 10'h004;
    stable = 1;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
      if (!ready && MsData_out !== cap) stable = 0;
    end while (!ready && n < 40);
    chk("b2b_gap", n, LAT + 1);
    chk("b2b_stable", stable, 1'b1);
    chk("b2b_line1", MsData_out[63:32], 32'hDEADBEEF);
    MsRead = 0;

    req(0, 1, 10'h006, 32'h0BAD_F00D, n);
    chk("wr_keeps_data", MsData_out[63:32], 32'hDEADBEEF);

`ifdef MAIN_MEM_STATS_EN
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    req(1, 0, 10'h000, 32'h0, n);
    req(0, 1, 10'h001, 32'h1111_1111, n);
    req(1, 0, 10'h004, 32'h0, n);
    req(0, 1, 10'h002, 32'h2222_2222, n);
    req(1, 0, 10'h008, 32'h0, n);
    @(negedge clk);
    chk("stats_rd3", rd_count, 16'd3);
    chk("stats_wr2", wr_count, 16'd2);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("stats_rd_rst", rd_count, 16'd0);
    chk("stats_wr_rst", wr_count, 16'd0);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
